// File: rtl/logic_reduce_acc.sv
// logic_reduce_acc
//   Folds a packet of WIDTH-bit operands into one result using a bitwise gate
//   mode chosen on the packet's first beat. NAND/NOR/XNOR are AND/OR/XOR folds
//   inverted once at the end. Illegal modes fold as AND and flag an error.
//   A packet also ends, with an error, when MAX_OPS operands arrive without
//   in_last.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             operand handshake
//   in_data, in_last, op          operand, end-of-packet, gate mode
//   out_valid/out_ready           result handshake
//   out_data, out_count, out_err  result, operand count, error flag
//                                 (all zero while out_valid is low)
module logic_reduce_acc #(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 16,
  localparam int CW     = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    count_reg;
  logic [2:0]       op_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CW-1:0]    out_count_reg;
  logic             out_err_reg;

  logic             accept;
  logic [2:0]       sel_op;
  logic [CW-1:0]    cnt_next;
  logic             at_max;
  logic             finish;
  logic             illegal;
  logic             invert;
  logic             is_or;
  logic             is_xor;
  logic [WIDTH-1:0] bit_fold;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] result;

  assign accept = in_valid & in_ready_reg;

  // Mid-packet the latched mode selects the base gate; op on the port is ignored.
  assign is_or  = (op_reg == 3'd1) | (op_reg == 3'd4);
  assign is_xor = (op_reg == 3'd2) | (op_reg == 3'd5);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fold
      assign bit_fold[gi] = is_or  ? (acc_reg[gi] | in_data[gi]) :
                            is_xor ? (acc_reg[gi] ^ in_data[gi]) :
                                     (acc_reg[gi] & in_data[gi]);
    end
  endgenerate

  always_comb begin
    sel_op   = (state_reg == IDLE) ? op : op_reg;
    cnt_next = (state_reg == IDLE) ? CW'(1) : count_reg + CW'(1);
    at_max   = (cnt_next == CW'(MAX_OPS));
    finish   = in_last | at_max;
    illegal  = sel_op[2] & sel_op[1];
    // Modes 3,4,5 are the inverted family; 6,7 are illegal and fold as plain AND.
    invert   = ~illegal & ((sel_op == 3'd3) | sel_op[2]);
    // The first beat simply loads the accumulator.
    fold     = (state_reg == IDLE) ? in_data : bit_fold;
    result   = invert ? ~fold : fold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      op_reg        <= 3'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            acc_reg   <= fold;
            count_reg <= cnt_next;
            op_reg    <= sel_op;
            if (finish) begin
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_data_reg  <= result;
              out_count_reg <= cnt_next;
              // Truncation only counts when the cap, not in_last, ended the packet.
              out_err_reg   <= illegal | (at_max & ~in_last);
            end else begin
              state_reg <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_err_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed bench for logic_reduce_acc (WIDTH=8, MAX_OPS=4).
module tb_logic_reduce_acc;

  localparam int WIDTH   = 8;
  localparam int MAX_OPS = 4;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [2:0]       op = 3'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_err;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  logic_reduce_acc #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-22s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-22s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [2:0] o);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    op       = o;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_consume_valid", 32'(out_valid), 32'd0);
    check("after_consume_data", 32'(out_data), 32'd0);
    check("after_consume_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input int c, input logic e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_count"}, 32'(out_count), 32'(c));
    check({tag, "_err"}, 32'(out_err), 32'(e));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    // AND F0 & 3C & FF = 30
    send(8'hF0, 1'b0, 3'd0);
    send(8'h3C, 1'b0, 3'd0);
    check("and_mid_valid", 32'(out_valid), 32'd0);
    send(8'hFF, 1'b1, 3'd0);
    check_result("and", 8'h30, 3, 1'b0);
    check("and_done_ready", 32'(in_ready), 32'd0);
    consume();

    // NAND single A5 -> 5A
    send(8'hA5, 1'b1, 3'd3);
    check_result("nand1", 8'h5A, 1, 1'b0);
    consume();

    // XOR 0F ^ FF = F0 held through 3 cycles of backpressure
    send(8'h0F, 1'b0, 3'd2);
    send(8'hFF, 1'b1, 3'd2);
    for (int i = 0; i < 3; i++) begin
      check("xor_hold_valid", 32'(out_valid), 32'd1);
      check("xor_hold_data", 32'(out_data), 32'hF0);
      check("xor_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    check_result("xor", 8'hF0, 2, 1'b0);
    consume();

    // OR truncated at MAX_OPS, then a fresh packet
    send(8'h01, 1'b0, 3'd1);
    send(8'h02, 1'b0, 3'd1);
    send(8'h04, 1'b0, 3'd1);
    check("or_mid_valid", 32'(out_valid), 32'd0);
    send(8'h08, 1'b0, 3'd1);
    check_result("or_trunc", 8'h0F, 4, 1'b1);
    consume();
    send(8'h55, 1'b1, 3'd1);
    check_result("or_next", 8'h55, 1, 1'b0);
    consume();

    // Illegal op folds as AND; op change mid-packet ignored
    send(8'hFF, 1'b0, 3'd6);
    send(8'h0F, 1'b1, 3'd1);
    check_result("illegal", 8'h0F, 2, 1'b1);
    consume();

    // Idle gaps in ACC keep the accumulator: OR 11 | 22 = 33
    send(8'h11, 1'b0, 3'd1);
    repeat (5) tick();
    check("gap_valid", 32'(out_valid), 32'd0);
    send(8'h22, 1'b1, 3'd4);
    check_result("gap_or", 8'h33, 2, 1'b0);
    consume();

    // Reset mid-packet discards the partial result
    send(8'hF0, 1'b0, 3'd0);
    send(8'h3C, 1'b0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_valid", 32'(out_valid), 32'd0);
      tick();
    end
    send(8'hAA, 1'b0, 3'd5);
    send(8'h55, 1'b1, 3'd5);
    check_result("xnor", 8'h00, 2, 1'b0);

    // Reset while DONE with out_ready high: reset wins, no handshake
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_count", 32'(out_count), 32'd0);
    check("donerst_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/logic_reduce_acc.md
LOGIC_REDUCE_ACC -- requirements
Module: logic_reduce_acc

Interface
REQ-001 Parameter: WIDTH, 8, operand and result bit width (>=1).
REQ-002 Parameter: MAX_OPS, 16, maximum operands per packet (>=1).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  operand beat valid.
REQ-007 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port: in_data  input  WIDTH  operand.
REQ-009 Port: in_last  input  1  final operand of the packet.
REQ-010 Port: op  input  3  gate mode: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 illegal.
REQ-011 Port: out_valid  output  1  result available.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: out_data  output  WIDTH  reduced result.
REQ-014 Port: out_count  output  CW = $clog2(MAX_OPS+1)  operands folded into out_data.
REQ-015 Port: out_err  output  1  illegal op or packet truncated at MAX_OPS.

Function
REQ-016 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-017 FSM states SHALL be IDLE, ACC, DONE; in_ready=1 in IDLE and ACC, 0 in DONE; out_valid=1 only in DONE.
REQ-018 IDLE, beat accepted: acc <= in_data, op latched, count <= 1; next state DONE if in_last or MAX_OPS==1, else ACC.
REQ-019 ACC, beat accepted: acc <= acc AND/OR/XOR in_data (base op of latched mode), count <= count+1; next state DONE if in_last or count+1==MAX_OPS, else stay ACC.
REQ-020 op SHALL be sampled only on the first beat; op changes mid-packet are ignored.
REQ-021 NAND/NOR/XNOR SHALL be computed as bitwise inversion of the final AND/OR/XOR reduction (a single-operand NAND packet yields ~in_data).
REQ-022 Illegal op SHALL reduce as AND and set out_err=1 for that packet.
REQ-023 Reaching MAX_OPS on a beat with in_last=0 SHALL end the packet and set out_err=1; the next accepted beat starts a new packet.
REQ-024 out_valid SHALL assert the cycle after the final beat is accepted (latency 1); out_data, out_count, out_err SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-025 DONE with out_ready=1: result consumed, next state IDLE; new beats accepted from the following cycle.
REQ-026 in_valid=0 in ACC SHALL hold state and accumulator indefinitely.
REQ-027 out_data, out_count, out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, acc=0, count=0, latched op=000, out_valid=0, out_data=0, out_count=0, out_err=0, in_ready=1 from the next cycle.
REQ-029 Reset mid-packet or while in DONE SHALL discard the partial or pending result with no output handshake.
REQ-030 rst SHALL take priority over any simultaneous beat or out_ready.

Verification (WIDTH=8, MAX_OPS=4 unless stated)
REQ-031 AND, beats 0xF0, 0x3C, 0xFF(last) -> out_data=0x30, out_count=3, out_err=0, out_valid one cycle after the last beat.
REQ-032 NAND, single beat 0xA5(last) -> out_data=0x5A, out_count=1, out_err=0.
REQ-033 XOR, beats 0x0F, 0xFF(last), out_ready held low 3 cycles -> out_data=0xF0 stable, in_ready=0 throughout, released on the 4th cycle.
REQ-034 OR, beats 0x01, 0x02, 0x04, 0x08, in_last never set -> out_data=0x0F, out_count=4, out_err=1; a following 0x55(last) yields 0x55, count 1, err 0.
REQ-035 op=110, beats 0xFF, 0x0F(last) -> out_data=0x0F, out_count=2, out_err=1; op switched to 001 after the first beat has no effect.
REQ-036 rst pulsed after 2 of 3 beats -> no out_valid; next packet XNOR 0xAA, 0x55(last) -> out_data=0x00, out_count=2.
